// File: rtl/even_odd_router.sv
// Parity router: steers each accepted number into an EVEN or ODD first-word-fall-through FIFO
// and keeps saturating per-class acceptance counts.

module even_odd_router_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              valid,
  output logic [DATA_W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] last_q;

  // Head is visible as soon as it is written; when empty the last popped word is held.
  assign full  = (count == CW'(DEPTH));
  assign valid = (count != '0);
  assign dout  = valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module even_odd_router #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] num,
  output logic              even_valid,
  input  logic              even_ready,
  output logic [DATA_W-1:0] even_data,
  output logic              odd_valid,
  input  logic              odd_ready,
  output logic [DATA_W-1:0] odd_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  even_cnt,
  output logic [CNT_W-1:0]  odd_cnt
);
  logic even_full;
  logic odd_full;
  logic accept;
  logic push_e;
  logic push_o;
  logic pop_e;
  logic pop_o;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Backpressure looks only at stored occupancy, so a same-cycle pop never frees a full slot.
  assign in_ready = !rst && !even_full && !odd_full;
  assign accept   = in_valid && in_ready;
  assign push_e   = accept && !num[0];
  assign push_o   = accept &&  num[0];
  assign pop_e    = even_valid && even_ready;
  assign pop_o    = odd_valid  && odd_ready;

  even_odd_router_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_even (
    .clk   (clk),
    .rst   (rst),
    .push  (push_e),
    .pop   (pop_e),
    .din   (num),
    .full  (even_full),
    .valid (even_valid),
    .dout  (even_data)
  );

  even_odd_router_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_odd (
    .clk   (clk),
    .rst   (rst),
    .push  (push_o),
    .pop   (pop_o),
    .din   (num),
    .full  (odd_full),
    .valid (odd_valid),
    .dout  (odd_data)
  );

  // Clear wins over a concurrent accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      even_cnt <= '0;
      odd_cnt  <= '0;
    end else if (cnt_clr) begin
      even_cnt <= '0;
      odd_cnt  <= '0;
    end else begin
      if (push_e) even_cnt <= sat_inc(even_cnt);
      if (push_o) odd_cnt  <= sat_inc(odd_cnt);
    end
  end
endmodule
